// File: rtl/puf_auth_pkg.sv
// Shared types and helpers for the PUF challenge/response verifier.
package puf_auth_pkg;

  localparam int unsigned DefChalW = 6;
  localparam int unsigned DefRespW = 8;
  localparam int unsigned DefHdW   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StLookup,
    StHamming,
    StReport
  } state_e;

  function automatic logic [DefRespW-1:0] maj3(input logic [DefRespW-1:0] a,
                                               input logic [DefRespW-1:0] b,
                                               input logic [DefRespW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/hd_serial_counter.sv
// Serial popcount: loads a vector and counts its set bits LSB first, one per cycle, saturating.
module hd_serial_counter #(
  parameter int unsigned RESP_W = 8,
  parameter int unsigned HD_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [RESP_W-1:0] vec_i,
  output logic              done_o,
  output logic [HD_W-1:0]   count_o
);

  localparam int unsigned BitW = $clog2(RESP_W + 1);

  logic [RESP_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   left_q, left_d;
  logic [HD_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = vec_i;
      left_d  = BitW'(RESP_W);
      cnt_d   = '0;
    end else if (left_q != '0) begin
      shift_d = shift_q >> 1;
      left_d  = left_q - BitW'(1);
      if (shift_q[0] && (cnt_q != HD_W'(RESP_W))) begin
        cnt_d = cnt_q + HD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      left_q  <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flags the cycle that consumes the last bit; count_o is final one cycle later.
  assign done_o  = (left_q == BitW'(1));
  assign count_o = cnt_q;

endmodule

// File: rtl/puf_auth_verifier.sv
// PUF enroll/verify controller with challenge-response table and Hamming-distance check.
// Optional MAJORITY_VOTE_EN: enroll stores the bitwise majority of three measurements.
module puf_auth_verifier
  import puf_auth_pkg::*;
#(
  parameter int unsigned CHAL_W      = DefChalW,
  parameter int unsigned RESP_W      = DefRespW,
  parameter int unsigned HD_W        = DefHdW,
  parameter int unsigned HD_THRESH   = 1,
  parameter int unsigned TIMEOUT_CYC = 120_000_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_enroll_i,
  input  logic [CHAL_W-1:0] cmd_chal_i,
  output logic              puf_start_o,
  output logic [CHAL_W-1:0] puf_chal_o,
  input  logic              puf_done_i,
  input  logic [RESP_W-1:0] puf_resp_i,
  output logic              res_valid_o,
  output logic              res_pass_o,
  output logic [HD_W-1:0]   res_hd_o,
  output logic              res_err_o
);

  localparam int unsigned Depth = 2 ** CHAL_W;
  localparam int unsigned TmoW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e            state_q, state_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic              enroll_q, enroll_d;
  logic              err_q, err_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              done_q;
  logic              res_pass_q;
  logic [HD_W-1:0]   res_hd_q;
  logic              res_err_q;
  logic [Depth-1:0]  valid_q;
  logic [RESP_W-1:0] mem_q [Depth];

  logic              rise;
  logic              tbl_we;
  logic [RESP_W-1:0] tbl_wdata;
  logic              hd_load;
  logic              hd_done;
  logic [HD_W-1:0]   hd_cnt;
  logic              rep_pass;
  logic [HD_W-1:0]   rep_hd;
  logic              in_report;

`ifdef MAJORITY_VOTE_EN
  logic [1:0]        rnd_q, rnd_d;
  logic [RESP_W-1:0] maj0_q, maj0_d;
  logic [RESP_W-1:0] maj1_q, maj1_d;
`endif

  assign rise = puf_done_i & ~done_q;

  always_comb begin
    state_d     = state_q;
    chal_d      = chal_q;
    enroll_d    = enroll_q;
    err_d       = err_q;
    resp_d      = resp_q;
    tmo_d       = tmo_q;
    puf_start_o = 1'b0;
    hd_load     = 1'b0;
    tbl_we      = 1'b0;
`ifdef MAJORITY_VOTE_EN
    rnd_d       = rnd_q;
    maj0_d      = maj0_q;
    maj1_d      = maj1_q;
    tbl_wdata   = maj3(maj0_q, maj1_q, resp_q);
`else
    tbl_wdata   = resp_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          chal_d   = cmd_chal_i;
          enroll_d = cmd_enroll_i;
          err_d    = 1'b0;
`ifdef MAJORITY_VOTE_EN
          rnd_d    = 2'd0;
`endif
          // Verifying an unenrolled challenge never touches the PUF.
          if (!cmd_enroll_i && !valid_q[cmd_chal_i]) begin
            err_d   = 1'b1;
            state_d = StReport;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        puf_start_o = 1'b1;
        tmo_d       = '0;
        state_d     = StWait;
      end
      StWait: begin
        if (rise) begin
`ifdef MAJORITY_VOTE_EN
          if (enroll_q && (rnd_q != 2'd2)) begin
            if (rnd_q == 2'd0) maj0_d = puf_resp_i;
            else               maj1_d = puf_resp_i;
            rnd_d   = rnd_q + 2'd1;
            state_d = StIssue;
          end else begin
            resp_d  = puf_resp_i;
            state_d = StLookup;
          end
`else
          resp_d  = puf_resp_i;
          state_d = StLookup;
`endif
        end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = StReport;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StLookup: begin
        if (enroll_q) begin
          tbl_we  = 1'b1;
          state_d = StReport;
        end else begin
          hd_load = 1'b1;
          state_d = StHamming;
        end
      end
      StHamming: begin
        if (hd_done) state_d = StReport;
      end
      StReport: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  hd_serial_counter #(
    .RESP_W (RESP_W),
    .HD_W   (HD_W)
  ) u_hd (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (hd_load),
    .vec_i   (resp_q ^ mem_q[chal_q]),
    .done_o  (hd_done),
    .count_o (hd_cnt)
  );

  // Result is live during REPORT and held in registers afterwards.
  assign in_report = (state_q == StReport);
  assign rep_hd    = (err_q || enroll_q) ? '0 : hd_cnt;
  assign rep_pass  = !err_q && (enroll_q || (hd_cnt <= HD_W'(HD_THRESH)));

  assign cmd_ready_o = (state_q == StIdle);
  assign puf_chal_o  = chal_q;
  assign res_valid_o = in_report;
  assign res_pass_o  = in_report ? rep_pass : res_pass_q;
  assign res_hd_o    = in_report ? rep_hd : res_hd_q;
  assign res_err_o   = in_report ? err_q : res_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      chal_q     <= '0;
      enroll_q   <= 1'b0;
      err_q      <= 1'b0;
      resp_q     <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      res_pass_q <= 1'b0;
      res_hd_q   <= '0;
      res_err_q  <= 1'b0;
      valid_q    <= '0;
`ifdef MAJORITY_VOTE_EN
      rnd_q      <= 2'd0;
      maj0_q     <= '0;
      maj1_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      chal_q   <= chal_d;
      enroll_q <= enroll_d;
      err_q    <= err_d;
      resp_q   <= resp_d;
      tmo_q    <= tmo_d;
      done_q   <= puf_done_i;
      if (in_report) begin
        res_pass_q <= rep_pass;
        res_hd_q   <= rep_hd;
        res_err_q  <= err_q;
      end
      if (tbl_we) valid_q[chal_q] <= 1'b1;
`ifdef MAJORITY_VOTE_EN
      rnd_q  <= rnd_d;
      maj0_q <= maj0_d;
      maj1_q <= maj1_d;
`endif
    end
  end

  // Table data needs no reset: entries are qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (tbl_we) mem_q[chal_q] <= tbl_wdata;
  end

endmodule
